// File: rtl/rc4_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : rc4_phase_scheduler
// Brief   : Sequences the RC4 S-init, key-schedule and keystream engines,
//           owns the shared S-RAM mux and enforces a per-phase watchdog.
// Revision: 1.0 - initial release
// ============================================================================
module rc4_phase_scheduler #(
  parameter int TIMEOUT = 16383,
  parameter int CNT_W   = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] key,
  output logic [23:0] key_out,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic [1:0]  phase,
  output logic [2:0]  eng_start,
  input  logic [2:0]  eng_done,
  input  logic [2:0]  eng_write,
  input  logic [23:0] eng_addr,
  input  logic [23:0] eng_data,
  output logic [7:0]  ram_address,
  output logic [7:0]  ram_data,
  output logic        ram_wren
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_RUN    = 3'd2,
    S_GAP    = 3'd3,
    S_FINISH = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_phase;
  logic [23:0]      r_key;
  logic             r_timeout_err;
  logic             w_act_done;
  logic             w_act_write;

  // Everything on the engine side is steered by the active phase index.
  always_comb begin
    w_act_done  = 1'b0;
    w_act_write = 1'b0;
    ram_address = 8'h00;
    ram_data    = 8'h00;
    case (r_phase)
      2'd0: begin
        w_act_done  = eng_done[0];
        w_act_write = eng_write[0];
        ram_address = eng_addr[7:0];
        ram_data    = eng_data[7:0];
      end
      2'd1: begin
        w_act_done  = eng_done[1];
        w_act_write = eng_write[1];
        ram_address = eng_addr[15:8];
        ram_data    = eng_data[15:8];
      end
      2'd2: begin
        w_act_done  = eng_done[2];
        w_act_write = eng_write[2];
        ram_address = eng_addr[23:16];
        ram_data    = eng_data[23:16];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    busy         = (r_state != S_IDLE);
    done         = (r_state == S_FINISH);
    ram_wren     = (r_state == S_RUN) && w_act_write;
    eng_start    = 3'b000;
    if (r_state == S_LAUNCH) begin
      case (r_phase)
        2'd0:    eng_start = 3'b001;
        2'd1:    eng_start = 3'b010;
        2'd2:    eng_start = 3'b100;
        default: eng_start = 3'b000;
      endcase
    end
    case (r_state)
      S_IDLE:   if (start) w_state_next = S_LAUNCH;
      S_LAUNCH: w_state_next = S_RUN;
      S_RUN: begin
        // A done arriving on the last watchdog cycle still counts as success.
        if (w_act_done)               w_state_next = S_GAP;
        else if (r_cnt == c_cnt_last) w_state_next = S_FAULT;
      end
      S_GAP:    w_state_next = (r_phase == 2'd2) ? S_FINISH : S_LAUNCH;
      S_FINISH: w_state_next = S_IDLE;
      S_FAULT:  w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt         <= '0;
      r_phase       <= 2'd0;
      r_key         <= 24'h000000;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_key         <= key;
            r_phase       <= 2'd0;
            r_timeout_err <= 1'b0;
          end
        end
        S_LAUNCH: r_cnt <= '0;
        S_RUN:    r_cnt <= r_cnt + 1'b1;
        S_GAP:    if (r_phase != 2'd2) r_phase <= r_phase + 2'd1;
        S_FINISH: r_phase <= 2'd0;
        S_FAULT: begin
          r_timeout_err <= 1'b1;
          r_phase       <= 2'd0;
        end
        default:  r_phase <= 2'd0;
      endcase
    end
  end

  assign key_out     = r_key;
  assign timeout_err = r_timeout_err;
  assign phase       = r_phase;

endmodule
`default_nettype wire

// File: tb/tb_rc4_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_rc4_phase_scheduler
// Brief   : Drives full runs open-loop and compares every cycle against a
//           run-timeline model derived from per-phase engine latencies.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rc4_phase_scheduler;

  localparam int T = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [23:0] key;
  logic [23:0] key_out;
  logic        busy;
  logic        done;
  logic        timeout_err;
  logic [1:0]  phase;
  logic [2:0]  eng_start;
  logic [2:0]  eng_done;
  logic [2:0]  eng_write;
  logic [23:0] eng_addr;
  logic [23:0] eng_data;
  logic [7:0]  ram_address;
  logic [7:0]  ram_data;
  logic        ram_wren;

  int total_cnt = 0;
  int pass_cnt  = 0;
  logic [23:0] prev_key;
  logic        prev_err;

  rc4_phase_scheduler #(.TIMEOUT(T), .CNT_W(7)) dut (
    .clk(clk), .reset(reset), .start(start), .key(key), .key_out(key_out),
    .busy(busy), .done(done), .timeout_err(timeout_err), .phase(phase),
    .eng_start(eng_start), .eng_done(eng_done), .eng_write(eng_write),
    .eng_addr(eng_addr), .eng_data(eng_data), .ram_address(ram_address),
    .ram_data(ram_data), .ram_wren(ram_wren)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int r, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s r=%0d: got %0h expected %0h", nm, r, act, exp);
    else
      pass_cnt++;
  endtask

  // One run: engine p reports done on its d[p]-th RUN cycle; phase 'hang'
  // never reports done. Cycle r=0 is the cycle start is sampled.
  task automatic run(input int d0, input int d1, input int d2, input int hang,
                     input int rst_at, output int last_busy);
    int d[3];
    int L[3];
    int nph, endc, ephase, act, runlen;
    bit fault, lastp;
    logic [2:0]  dn, es;
    logic [23:0] cap, a_sel, d_sel;
    d = '{d0, d1, d2};
    L = '{1, 0, 0};
    fault = 0; nph = 3; endc = 0; last_busy = -1; cap = prev_key;
    for (int p = 0; p < 3; p++) begin
      if (!fault) begin
        if (hang == p) begin
          fault = 1; nph = p + 1; endc = L[p] + T + 1;
        end else if (p < 2) L[p+1] = L[p] + d[p] + 2;
        else endc = L[2] + d[2] + 2;
      end
    end
    for (int r = 0; r <= endc + 3; r++) begin
      @(negedge clk);
      start = (r == 0) ? 1'b1 : ((r <= endc) ? 1'($urandom % 2) : 1'b0);
      key = 24'($urandom); eng_write = 3'($urandom);
      eng_addr = 24'($urandom); eng_data = 24'($urandom);
      dn = 3'($urandom); ephase = 0; act = -1; es = 3'b000;
      for (int p = 0; p < nph; p++) begin
        lastp  = fault && (p == nph - 1);
        runlen = lastp ? T : d[p];
        if (r >= L[p] && r <= L[p] + runlen + 1) ephase = p;
        if (r >= L[p] + 1 && r <= L[p] + runlen) begin
          act = p;
          dn[p] = !lastp && (r == L[p] + d[p]);
        end
        if (r == L[p]) es[p] = 1'b1;
      end
      if (!fault && r == endc) ephase = 2;
      if (r == 0) cap = key;
      eng_done = dn;
      if (r == rst_at) reset = 1'b1;
      #1;
      if (r == rst_at) begin
        chk("rst_busy", r, 32'(busy), 0);
        chk("rst_done", r, 32'(done), 0);
        chk("rst_err", r, 32'(timeout_err), 0);
        chk("rst_phase", r, 32'(phase), 0);
        chk("rst_start", r, 32'(eng_start), 0);
        chk("rst_wren", r, 32'(ram_wren), 0);
        chk("rst_key", r, 32'(key_out), 0);
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        prev_key = 24'h0; prev_err = 1'b0;
        return;
      end
      a_sel = eng_addr >> (8 * ephase);
      d_sel = eng_data >> (8 * ephase);
      chk("busy", r, 32'(busy), 32'(r >= 1 && r <= endc));
      chk("done", r, 32'(done), 32'(!fault && r == endc));
      chk("eng_start", r, 32'(eng_start), 32'(es));
      chk("phase", r, 32'(phase), 32'(ephase));
      chk("timeout_err", r, 32'(timeout_err),
          32'((r <= 0) ? prev_err : ((r <= endc) ? 1'b0 : fault)));
      chk("key_out", r, 32'(key_out), 32'((r <= 0) ? prev_key : cap));
      chk("ram_wren", r, 32'(ram_wren), 32'(act >= 0 && eng_write[act]));
      chk("ram_address", r, 32'(ram_address), 32'(a_sel[7:0]));
      chk("ram_data", r, 32'(ram_data), 32'(d_sel[7:0]));
      if (busy) last_busy = r;
    end
    prev_key = cap; prev_err = fault;
  endtask

  typedef struct {
    int d0; int d1; int d2; int hang; int exp_end;
  } vec_t;

  initial begin
    vec_t tbl[5];
    int lb, hg;
    int dr[3];
    tbl[0] = '{10, 20, 30, 3, 67};   // nominal engine latencies
    tbl[1] = '{T,  1,  T,  3, 136};  // done lands on the last watchdog cycle
    tbl[2] = '{5,  0,  0,  1, 73};   // key-schedule engine hangs
    tbl[3] = '{1,  1,  1,  3, 10};   // minimum latencies, clears prior fault
    tbl[4] = '{0,  0,  0,  0, 66};   // S-init engine hangs

    reset = 1'b1; start = 1'b0; key = 24'h0;
    eng_done = 3'b0; eng_write = 3'b0; eng_addr = 24'h0; eng_data = 24'h0;
    prev_key = 24'h0; prev_err = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", -1, 32'(busy), 0);
    chk("reset_done", -1, 32'(done), 0);
    chk("reset_err", -1, 32'(timeout_err), 0);
    chk("reset_phase", -1, 32'(phase), 0);
    chk("reset_start", -1, 32'(eng_start), 0);
    chk("reset_key", -1, 32'(key_out), 0);
    chk("reset_wren", -1, 32'(ram_wren), 0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run(tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].hang, -1, lb);
      chk("table_end", i, 32'(lb), 32'(tbl[i].exp_end));
    end

    // Reset in the middle of phase 1 RUN, then a clean restart from phase 0.
    run(10, 20, 30, 3, 20, lb);
    run(10, 20, 30, 3, -1, lb);
    chk("restart_end", 0, 32'(lb), 67);

    for (int i = 0; i < 20; i++) begin
      for (int p = 0; p < 3; p++) begin
        case ($urandom % 4)
          0:       dr[p] = 1;
          1:       dr[p] = T;
          default: dr[p] = int'($urandom_range(1, T));
        endcase
      end
      hg = ($urandom % 4 == 0) ? int'($urandom % 3) : 3;
      run(dr[0], dr[1], dr[2], hg, -1, lb);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
